wave_capture_engine: RTL

WAVE_CAPTURE_ENGINE -- requirements
Module: wave_capture_engine

---
 rtl/wave_capture_engine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wave_capture_engine.sv
// Multi-channel triggered waveform capture: circular pre/post-trigger buffer
// with a valid/ready readout stream of one record per arm.
module wave_capture_engine #(
  parameter  int N_CH   = 2,
  parameter  int DATA_W = 14,
  parameter  int DEPTH  = 1024,
  parameter  int AW     = $clog2(DEPTH),
  localparam int SW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic [N_CH*DATA_W-1:0]   adc_data,
  input  logic [SW-1:0]            trig_source,
  input  logic                     trig_slope,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic [AW-1:0]            pretrig,
  input  logic                     arm,
  input  logic                     abort,
  output logic [N_CH*DATA_W-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic                     busy,
  output logic [15:0]              wave_number
);
  localparam int W = N_CH * DATA_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREFILL = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   N_WORDS  = (AW+1)'(DEPTH);

  logic [2:0]        r_state;
  logic [W-1:0]      r_s;
  logic [W-1:0]      r_s_prev;
  logic [W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_fill_cnt;
  logic [AW-1:0]     r_pretrig;
  logic [SW-1:0]     r_src;
  logic              r_slope;
  logic [DATA_W-1:0] r_level;
  logic [AW-1:0]     r_trig_addr;
  logic [AW:0]       r_rd_cnt;
  logic [W-1:0]      r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [15:0]       r_wave;

  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_prev;
  logic              w_trig;
  logic              w_write;
  logic              w_xfer;
  logic              w_load;
  logic [AW-1:0]     w_rd_addr;

  assign w_cur     = r_s[int'(r_src)*DATA_W +: DATA_W];
  assign w_prev    = r_s_prev[int'(r_src)*DATA_W +: DATA_W];
  assign w_trig    = r_slope ? ((w_prev > r_level) && (w_cur <= r_level))
                             : ((w_prev < r_level) && (w_cur >= r_level));
  assign w_write   = (r_state == S_PREFILL) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_xfer    = r_rd_valid && rd_ready;
  // Output register doubles as the prefetch stage: it refills whenever empty or draining.
  assign w_load    = (r_state == S_READOUT) && (r_rd_cnt != N_WORDS) && (!r_rd_valid || rd_ready);
  assign w_rd_addr = r_trig_addr - r_pretrig + r_rd_cnt[AW-1:0];

  always_ff @(posedge sys_clk) begin
    if (w_write) r_mem[r_wr_ptr] <= r_s;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_s_prev    <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_pretrig   <= '0;
      r_src       <= '0;
      r_slope     <= 1'b0;
      r_level     <= '0;
      r_trig_addr <= '0;
      r_rd_cnt    <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_wave      <= '0;
    end else begin
      r_s      <= adc_data;
      r_s_prev <= r_s;
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;

      if (abort) begin
        r_state    <= S_IDLE;
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (arm) begin
              r_pretrig  <= pretrig;
              r_src      <= trig_source;
              r_slope    <= trig_slope;
              r_level    <= trig_level;
              r_fill_cnt <= '0;
              r_state    <= S_PREFILL;
            end
          end
          S_PREFILL: begin
            if (r_fill_cnt == r_pretrig) r_state <= S_ARMED;
            else                         r_fill_cnt <= r_fill_cnt + 1'b1;
          end
          S_ARMED: begin
            if (w_trig) begin
              r_trig_addr <= r_wr_ptr;
              r_fill_cnt  <= '0;
              r_rd_cnt    <= '0;
              // Maximum pretrig leaves no post-trigger samples to write.
              r_state     <= (r_pretrig == LAST_IDX) ? S_READOUT : S_POST;
            end
          end
          S_POST: begin
            if (r_fill_cnt == (LAST_IDX - AW'(1) - r_pretrig)) r_state <= S_READOUT;
            else                                                r_fill_cnt <= r_fill_cnt + 1'b1;
          end
          S_READOUT: begin
            if (w_load) begin
              r_rd_data  <= r_mem[w_rd_addr];
              r_rd_valid <= 1'b1;
              r_rd_last  <= (r_rd_cnt[AW-1:0] == LAST_IDX);
              r_rd_cnt   <= r_rd_cnt + 1'b1;
            end else if (w_xfer) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
            end
            if (w_xfer && r_rd_last) begin
              r_wave  <= r_wave + 16'd1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rd_last     = r_rd_last;
  assign busy        = (r_state != S_IDLE);
  assign wave_number = r_wave;
endmodule
